// File: rtl/nsa_pkg.sv
// -----------------------------------------------------------------------------
// nsa_pkg
// Shared definitions for the nibble-serial adder:
//   NIBBLE  - width of one serial digit (4 bits)
//   state_t - control states IDLE / RUN / DONE
// -----------------------------------------------------------------------------
package nsa_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nsa_pkg

// File: rtl/cla4.sv
// -----------------------------------------------------------------------------
// cla4
// 4-bit carry-lookahead adder. Every carry is formed directly from the
// generate/propagate terms, so no carry ripples through the sum bits.
// Ports:
//   a, b  (in,  4) - addends
//   cin   (in,  1) - carry-in
//   s     (out, 4) - sum
//   cout  (out, 1) - carry-out
// -----------------------------------------------------------------------------
module cla4
  import nsa_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout
);

  logic [NIBBLE-1:0] g;
  logic [NIBBLE-1:0] p;
  logic [NIBBLE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[NIBBLE-1:0];
  assign cout = c[NIBBLE];

endmodule : cla4

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Adds two WIDTH-bit operands plus a carry-in one nibble per clock, least
// significant nibble first, through a single shared cla4. A valid/ready
// handshake on each side; the result is held in DONE until consumed.
//
// Parameter:
//   WIDTH - operand/sum width, a multiple of 4 and at least 4 (default 16)
// Ports:
//   clk        (in)         clock, rising edge
//   rst        (in)         synchronous active-high reset
//   in_valid   (in)         a/b/cin are valid
//   in_ready   (out)        block accepts an operand set (IDLE only)
//   a, b       (in,  WIDTH) addends
//   cin        (in)         carry-in to nibble 0
//   out_valid  (out)        s/cout hold a completed result (DONE only)
//   out_ready  (in)         consumer takes the result
//   s          (out, WIDTH) registered sum
//   cout       (out)        registered carry-out of the top nibble
//   ovf        (out)        registered signed overflow
// Build option:
//   NSA_OVERFLOW_EN - when defined, adds the ovf port and its logic.
//
// Timing: handshake at edge k -> nibbles in cycles k+1..k+WIDTH/4,
// out_valid from cycle k+WIDTH/4+1.
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE;
  // Keep the index at least one bit wide so WIDTH=4 still elaborates.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             cout_reg;
`ifdef NSA_OVERFLOW_EN
  logic             ovf_reg;
`endif

  logic              accept;
  logic              step;
  logic              last;

  logic [NIBBLE-1:0] nib_a [NIBBLES];
  logic [NIBBLE-1:0] nib_b [NIBBLES];
  logic [NIBBLE-1:0] cur_a;
  logic [NIBBLE-1:0] cur_b;
  logic              nib_cin;
  logic [NIBBLE-1:0] nib_sum;
  logic              nib_cout;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // in_ready stays low here, so a new set is only taken one cycle
        // after the result handshake.
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Nibble select and the shared adder
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_split
      assign nib_a[gi] = a_reg[gi*NIBBLE +: NIBBLE];
      assign nib_b[gi] = b_reg[gi*NIBBLE +: NIBBLE];
    end
  endgenerate

  assign last    = (idx_reg == LAST_IDX);
  assign cur_a   = nib_a[idx_reg];
  assign cur_b   = nib_b[idx_reg];
  // Nibble 0 takes the operand carry-in; later nibbles chain the stored carry.
  assign nib_cin = (idx_reg == '0) ? cin_reg : carry_reg;

  cla4 u_cla4 (
    .a    (cur_a),
    .b    (cur_b),
    .cin  (nib_cin),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // ---------------------------------------------------------------------------
  // Operand latch, carry chain, index and final flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        cin_reg <= cin;
        idx_reg <= '0;
      end
      if (step) begin
        carry_reg <= nib_cout;
        // Hold on the last nibble rather than wrapping back to 0.
        if (!last) begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
        if (last) begin
          cout_reg <= nib_cout;
        end
      end
    end
  end

`ifdef NSA_OVERFLOW_EN
  // Signed overflow: like-signed operands producing a sum of the other sign.
  // The sum's sign bit is nib_sum[3] while the top nibble is being added.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (step && last) begin
      ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (nib_sum[NIBBLE-1] != a_reg[WIDTH-1]);
    end
  end

  assign ovf = ovf_reg;
`endif

  // ---------------------------------------------------------------------------
  // Sum register, one 4-bit slice per nibble position
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_sum
      logic [NIBBLE-1:0] sum_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_reg <= '0;
        end else if (step && (idx_reg == IDX_W'(gi))) begin
          sum_reg <= nib_sum;
        end
      end

      assign s[gi*NIBBLE +: NIBBLE] = sum_reg;
    end
  endgenerate

  assign cout = cout_reg;

endmodule : nibble_serial_adder
